// File: rtl/cycle_pkg.sv
// Shared definitions for the serial pattern generator: FSM encoding and the
// default pattern, also used by the matching detector bench.
package cycle_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          DEFAULT_PAT_W   = 6;
    localparam logic [5:0]  DEFAULT_PATTERN = 6'b101011;

endpackage

// File: rtl/cycle_generator.sv
// Serial pattern generator: shifts a stored pattern out MSB first, a given
// number of times (0 = until stopped), with registered out/out_valid/busy/done.
module cycle_generator
    import cycle_pkg::*;
#(
    parameter int                PAT_W   = DEFAULT_PAT_W,
    parameter logic [PAT_W-1:0]  PATTERN = DEFAULT_PATTERN,
    parameter int                CNT_W   = 4
) (
    input  logic              clk,
    input  logic              r,
    input  logic              load,
    input  logic [PAT_W-1:0]  pat_in,
    input  logic [CNT_W-1:0]  reps,
    input  logic              start,
    input  logic              stop,
    output logic              out,
    output logic              out_valid,
    output logic              busy,
    output logic              done
);

    localparam int              IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(PAT_W - 1);

    state_t             state, state_next;
    logic [PAT_W-1:0]   pattern, pattern_next;
    logic [CNT_W-1:0]   rep_cnt, rep_cnt_next;
    logic [IDX_W-1:0]   index, index_next;
    logic               out_next, out_valid_next, busy_next, done_next;

    // index always names the bit currently on out, so the registered output
    // is loaded with the bit the index will point at after this edge.
    always_comb begin
        state_next     = state;
        pattern_next   = pattern;
        rep_cnt_next   = rep_cnt;
        index_next     = index;
        out_next       = 1'b0;
        out_valid_next = 1'b0;
        busy_next      = 1'b0;
        done_next      = 1'b0;

        case (state)
            IDLE: begin
                if (load) begin
                    pattern_next = pat_in;
                end
                if (start) begin
                    state_next     = SEND;
                    rep_cnt_next   = reps;
                    index_next     = LAST;
                    out_next       = pattern_next[LAST];
                    out_valid_next = 1'b1;
                    busy_next      = 1'b1;
                end
            end

            SEND: begin
                if (stop) begin
                    state_next = IDLE;
                    index_next = LAST;
                end else if (index == '0) begin
                    index_next = LAST;
                    if (rep_cnt == CNT_W'(1)) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        if (rep_cnt != '0) begin
                            rep_cnt_next = rep_cnt - CNT_W'(1);
                        end
                        out_next       = pattern[LAST];
                        out_valid_next = 1'b1;
                        busy_next      = 1'b1;
                    end
                end else begin
                    index_next     = index - IDX_W'(1);
                    out_next       = pattern[index_next];
                    out_valid_next = 1'b1;
                    busy_next      = 1'b1;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
                index_next = LAST;
            end
        endcase
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state     <= IDLE;
            pattern   <= PATTERN;
            rep_cnt   <= '0;
            index     <= LAST;
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            pattern   <= pattern_next;
            rep_cnt   <= rep_cnt_next;
            index     <= index_next;
            out       <= out_next;
            out_valid <= out_valid_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

endmodule

// File: tb/tb_cycle_generator.sv
// Directed bench for cycle_generator: each task drives one scenario and checks
// the serial stream and status flags against hand-computed values.
module tb_cycle_generator;

    logic       clk = 1'b0;
    logic       r = 1'b0;
    logic       load = 1'b0;
    logic [5:0] pat_in = '0;
    logic [3:0] reps = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       out, out_valid, busy, done;

    int checks = 0;
    int failures = 0;

    cycle_generator dut (
        .clk       (clk),
        .r         (r),
        .load      (load),
        .pat_in    (pat_in),
        .reps      (reps),
        .start     (start),
        .stop      (stop),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic do_reset();
        r = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
        #3;
        repeat (2) @(negedge clk);
        r = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_tx(input logic [3:0] n);
        reps = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic collect(input int n, output logic [31:0] bits, output int valid_cycles);
        bits = '0;
        valid_cycles = 0;
        for (int i = 0; i < n; i++) begin
            bits = {bits[30:0], out};
            if (out_valid === 1'b1 && busy === 1'b1) valid_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (out !== 1'b0) begin failures++; $display("[TB] FAIL reset_out: got %b expected 0", out); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    endtask

    task automatic test_single_rep();
        logic [31:0] bits;
        int v;
        do_reset();
        start_tx(4'd1);
        collect(6, bits, v);
        checks++; if (bits[5:0] !== 6'b101011) begin failures++; $display("[TB] FAIL single_bits: got %b expected 101011", bits[5:0]); end
        checks++; if (v !== 6) begin failures++; $display("[TB] FAIL single_valid: got %0d expected 6", v); end
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL single_done: got %b expected 1", done); end
        checks++; if ({busy, out_valid, out} !== 3'b000) begin failures++; $display("[TB] FAIL single_done_flags: got %b expected 000", {busy, out_valid, out}); end
        @(negedge clk);
        checks++; if ({done, busy, out_valid} !== 3'b000) begin failures++; $display("[TB] FAIL single_idle: got %b expected 000", {done, busy, out_valid}); end
    endtask

    task automatic test_load_reps2();
        logic [31:0] bits;
        int v, pulses;
        do_reset();
        pat_in = 6'b110010;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        start_tx(4'd2);
        collect(12, bits, v);
        checks++; if (bits[11:0] !== 12'b110010110010) begin failures++; $display("[TB] FAIL reps2_bits: got %b expected 110010110010", bits[11:0]); end
        checks++; if (v !== 12) begin failures++; $display("[TB] FAIL reps2_valid: got %0d expected 12", v); end
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL reps2_done: got %b expected 1", done); end
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("[TB] FAIL reps2_extra_done: got %0d expected 0", pulses); end
    endtask

    task automatic test_continuous_stop();
        logic [13:0] bits;
        int v, pulses;
        do_reset();
        start_tx(4'd0);
        bits = '0; v = 0; pulses = 0;
        for (int i = 0; i < 14; i++) begin
            bits = {bits[12:0], out};
            if (out_valid === 1'b1) v++;
            if (done === 1'b1) pulses++;
            if (i == 13) stop = 1'b1;
            @(negedge clk);
        end
        stop = 1'b0;
        checks++; if (bits !== 14'b10101110101110) begin failures++; $display("[TB] FAIL cont_bits: got %b expected 10101110101110", bits); end
        checks++; if (v !== 14) begin failures++; $display("[TB] FAIL cont_valid: got %0d expected 14", v); end
        checks++; if ({out_valid, busy, out} !== 3'b000) begin failures++; $display("[TB] FAIL cont_after_stop: got %b expected 000", {out_valid, busy, out}); end
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++; if (pulses !== 0) begin failures++; $display("[TB] FAIL cont_done_seen: got %0d expected 0", pulses); end
    endtask

    task automatic test_load_and_start();
        logic [31:0] bits;
        int v;
        do_reset();
        pat_in = 6'b011111;
        reps = 4'd1;
        load = 1'b1;
        start = 1'b1;
        @(negedge clk);
        load = 1'b0;
        start = 1'b0;
        collect(6, bits, v);
        checks++; if (bits[5:0] !== 6'b011111) begin failures++; $display("[TB] FAIL ldst_bits: got %b expected 011111", bits[5:0]); end
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL ldst_done: got %b expected 1", done); end
        @(negedge clk);
    endtask

    task automatic test_ignore_mid_send();
        logic [31:0] bits;
        int v;
        do_reset();
        start_tx(4'd1);
        bits = '0;
        for (int i = 0; i < 6; i++) begin
            bits = {bits[30:0], out};
            if (i == 1) begin start = 1'b1; load = 1'b1; pat_in = 6'b000000; end
            if (i == 3) begin start = 1'b0; load = 1'b0; end
            @(negedge clk);
        end
        checks++; if (bits[5:0] !== 6'b101011) begin failures++; $display("[TB] FAIL ignore_bits: got %b expected 101011", bits[5:0]); end
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL ignore_done: got %b expected 1", done); end
        @(negedge clk);
        start_tx(4'd1);
        collect(6, bits, v);
        checks++; if (bits[5:0] !== 6'b101011) begin failures++; $display("[TB] FAIL ignore_pattern_kept: got %b expected 101011", bits[5:0]); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] bits;
        int v;
        do_reset();
        reps = 4'd1;
        start = 1'b1;
        @(negedge clk);
        collect(6, bits, v);
        checks++; if (bits[5:0] !== 6'b101011) begin failures++; $display("[TB] FAIL b2b_first: got %b expected 101011", bits[5:0]); end
        checks++; if ({done, out_valid} !== 2'b10) begin failures++; $display("[TB] FAIL b2b_done_cycle: got %b expected 10", {done, out_valid}); end
        @(negedge clk);
        checks++; if ({done, out_valid, busy} !== 3'b000) begin failures++; $display("[TB] FAIL b2b_idle_gap: got %b expected 000", {done, out_valid, busy}); end
        @(negedge clk);
        start = 1'b0;
        collect(6, bits, v);
        checks++; if (bits[5:0] !== 6'b101011 || v !== 6) begin failures++; $display("[TB] FAIL b2b_second: got %b/%0d expected 101011/6", bits[5:0], v); end
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL b2b_second_done: got %b expected 1", done); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        logic [31:0] bits;
        int v;
        do_reset();
        pat_in = 6'b000111;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        start_tx(4'd0);
        collect(3, bits, v);
        checks++; if (bits[2:0] !== 3'b000 || out_valid !== 1'b1) begin failures++; $display("[TB] FAIL areset_pre: got %b/%b expected 000/1", bits[2:0], out_valid); end
        #2;
        r = 1'b0;
        #1;
        checks++; if ({out, out_valid, busy, done} !== 4'b0000) begin failures++; $display("[TB] FAIL areset_immediate: got %b expected 0000", {out, out_valid, busy, done}); end
        @(negedge clk);
        r = 1'b1;
        @(negedge clk);
        start_tx(4'd1);
        collect(6, bits, v);
        checks++; if (bits[5:0] !== 6'b101011) begin failures++; $display("[TB] FAIL areset_restart: got %b expected 101011", bits[5:0]); end
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL areset_done: got %b expected 1", done); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_rep();
        test_load_reps2();
        test_continuous_stop();
        test_load_and_start();
        test_ignore_mid_send();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/cycle_generator.md
CYCLE_GENERATOR -- requirements
Module: cycle_generator

Interface
REQ-001 The block SHALL provide parameter PAT_W, default 6, giving the pattern width in bits.
REQ-002 The block SHALL provide parameter PATTERN, default 6'b101011, giving the pattern loaded at reset.
REQ-003 The block SHALL provide parameter CNT_W, default 4, giving the repetition-count width.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port r, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port load, input, 1 bit: pattern-register write strobe.
REQ-007 Port pat_in, input, PAT_W bits: pattern written on load.
REQ-008 Port reps, input, CNT_W bits: repetition count sampled on start; 0 means continuous.
REQ-009 Port start, input, 1 bit: request to begin transmission.
REQ-010 Port stop, input, 1 bit: abort of a transmission in progress.
REQ-011 Port out, output, 1 bit: serial data, MSB of the pattern first.
REQ-012 Port out_valid, output, 1 bit: out carries a pattern bit this cycle.
REQ-013 Port busy, output, 1 bit: a transmission is in progress.
REQ-014 Port done, output, 1 bit: one-cycle pulse on normal completion.

Function
REQ-015 Every output SHALL be driven directly from a flip-flop.
REQ-016 The FSM SHALL have exactly three states: IDLE, SEND and DONE.
REQ-017 IDLE: a load=1 on an edge SHALL copy pat_in into the pattern register.
REQ-018 IDLE: a start=1 on an edge SHALL latch reps into the repetition counter, set the bit index to PAT_W-1 and enter SEND.
REQ-019 Start latency SHALL be one cycle: the first bit is valid in the cycle after the edge that sampled start.
REQ-020 SEND: each cycle SHALL drive out = pattern[index] with out_valid=1 and busy=1, then decrement index.
REQ-021 At index 0 the index SHALL wrap to PAT_W-1, and the repetition counter SHALL decrement unless it was latched as 0.
REQ-022 After bit 0 of the final repetition (counter 1), the FSM SHALL enter DONE.
REQ-023 DONE SHALL last exactly one cycle with done=1, busy=0 and out_valid=0, then return to IDLE.
REQ-024 When reps=0 was latched, SEND SHALL repeat the pattern indefinitely until stop.
REQ-025 stop=1 sampled in SEND SHALL force IDLE at that edge: out_valid=0 and busy=0 from the next cycle, no done pulse, remaining bits discarded.
REQ-026 start sampled in SEND or DONE SHALL be ignored.
REQ-027 load sampled in SEND or DONE SHALL be ignored; the pattern register changes only in IDLE.
REQ-028 load and start together in IDLE SHALL both take effect, and transmission SHALL use the newly loaded pat_in.
REQ-029 stop sampled in IDLE or DONE SHALL have no effect.
REQ-030 out SHALL be 0 whenever out_valid=0.
REQ-031 Back-to-back transmissions SHALL be separated by at least the DONE cycle plus one IDLE cycle.

Reset
REQ-032 r=0 SHALL immediately, without waiting for clk, force: state IDLE, out=0, out_valid=0, busy=0, done=0, pattern register=PATTERN, repetition counter=0, index=PAT_W-1.
REQ-033 Reset asserted mid-transmission SHALL abort it with no done pulse.
REQ-034 After r returns to 1, the first start sampled SHALL behave per REQ-018.

Structure
REQ-035 The state encoding (IDLE=0, SEND=1, DONE=2, 2 bits) and the default PATTERN constant SHALL live in a shared package, cycle_pkg, reused by the detector bench.
REQ-036 The design SHALL be a single module with no sub-modules; the index/repetition counter logic SHALL stay inline.

Verification
REQ-037 Reset, reps=1, start -> out=1,0,1,0,1,1 over 6 cycles with out_valid=1, then done=1 for one cycle, then idle.
REQ-038 load pat_in=6'b110010 in IDLE, then reps=2, start -> 110010110010, then a single done pulse.
REQ-039 reps=0, start, stop after 14 valid bits -> 101011101011 10, out_valid=0 the next cycle, done never asserted.
REQ-040 load=1 and start=1 on the same edge with pat_in=6'b011111 -> first transmitted bits are 011111.
REQ-041 Assert start and load (pat_in=6'b000000) mid-SEND -> both ignored, original pattern completes unchanged.
REQ-042 Assert r=0 asynchronously mid-bit during SEND -> all outputs 0 immediately; the next start transmits PATTERN (101011) from the MSB.
